// File: rtl/uart_rx_pkg.sv
// Shared definitions for the system-bus UART receiver: register offsets and FSM states.
package uart_rx_pkg;

    localparam logic [31:0] ADDR_DATA      = 32'h00;
    localparam logic [31:0] ADDR_VALID     = 32'h04;
    localparam logic [31:0] ADDR_BUSY      = 32'h08;
    localparam logic [31:0] ADDR_DIV       = 32'h0C;
    localparam logic [31:0] ADDR_PARITY_EN = 32'h10;
    localparam logic [31:0] ADDR_STOPBITS  = 32'h14;
    localparam logic [31:0] ADDR_ERR       = 32'h18;
    localparam logic [31:0] ADDR_RST       = 32'h24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// UART receive engine: rx synchroniser, bit-timing counter and frame FSM.
// Emits a delivery strobe with the byte plus parity/framing error strobes.
module uart_rx_core
    import uart_rx_pkg::*;
(
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        clear_i,
    input  logic        rx_i,
    input  logic [15:0] div_i,
    input  logic        parity_en_i,
    input  logic        two_stop_i,
    output logic        busy_o,
    output logic [7:0]  data_o,
    output logic        deliver_o,
    output logic        parity_err_o,
    output logic        frame_err_o
);

    rx_state_t   state;
    logic        rx_meta;
    logic        rxs;
    logic [15:0] cnt;
    logic [15:0] div_q;
    logic        parity_en_q;
    logic        two_stop_q;
    logic        stop_left;
    logic [2:0]  bit_idx;
    logic [7:0]  shift;
    logic        tick;

    // A sample is taken in the cycle where the counter reaches 1, then it reloads DIV.
    assign tick = (cnt == 16'd1);

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            state       <= ST_IDLE;
            cnt         <= '0;
            div_q       <= '0;
            parity_en_q <= 1'b0;
            two_stop_q  <= 1'b0;
            stop_left   <= 1'b0;
            bit_idx     <= '0;
            shift       <= '0;
        end else if (clear_i) begin
            rx_meta     <= 1'b1;
            rxs         <= 1'b1;
            state       <= ST_IDLE;
            cnt         <= '0;
            div_q       <= '0;
            parity_en_q <= 1'b0;
            two_stop_q  <= 1'b0;
            stop_left   <= 1'b0;
            bit_idx     <= '0;
            shift       <= '0;
        end else begin
            rx_meta <= rx_i;
            rxs     <= rx_meta;
            if (state != ST_IDLE) begin
                cnt <= tick ? div_q : cnt - 16'd1;
            end
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state       <= ST_START;
                        cnt         <= div_i >> 1;
                        div_q       <= div_i;
                        parity_en_q <= parity_en_i;
                        two_stop_q  <= two_stop_i;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state   <= rxs ? ST_IDLE : ST_DATA;
                        bit_idx <= '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shift   <= {rxs, shift[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state     <= parity_en_q ? ST_PARITY : ST_STOP;
                            stop_left <= two_stop_q;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (!rxs || !stop_left) begin
                            state <= ST_IDLE;
                        end
                        stop_left <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_o       = (state != ST_IDLE);
    assign data_o       = shift;
    assign deliver_o    = (state == ST_STOP) && tick && rxs && !stop_left;
    assign frame_err_o  = (state == ST_STOP) && tick && !rxs;
    assign parity_err_o = (state == ST_PARITY) && tick && ((^shift) ^ rxs);

endmodule

// File: rtl/uart_rx_sb_ctrl.sv
// System-bus UART receiver: register window, interrupt request and read mux
// around the uart_rx_core frame engine.
module uart_rx_sb_ctrl
    import uart_rx_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd1042
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        interrupt_request_o,
    input  logic        interrupt_return_i,
    input  logic        rx_i
);

    logic        wr;
    logic        rd;
    logic        soft_rst;
    logic        data_rd;
    logic        err_wr;
    logic        busy;
    logic [7:0]  core_data;
    logic        deliver;
    logic        parity_err;
    logic        frame_err;
    logic [7:0]  data_q;
    logic        valid_q;
    logic [15:0] div_q;
    logic        parity_en_q;
    logic        two_stop_q;
    logic [2:0]  err_q;
    logic [31:0] rd_mux;

    assign wr       = req_i & write_enable_i;
    assign rd       = req_i & ~write_enable_i;
    assign soft_rst = wr && (addr_i == ADDR_RST) && write_data_i[0];
    assign data_rd  = rd && (addr_i == ADDR_DATA);
    assign err_wr   = wr && (addr_i == ADDR_ERR);

    uart_rx_core u_core (
        .clk_i        (clk_i),
        .resetn_i     (resetn_i),
        .clear_i      (soft_rst),
        .rx_i         (rx_i),
        .div_i        (div_q),
        .parity_en_i  (parity_en_q),
        .two_stop_i   (two_stop_q),
        .busy_o       (busy),
        .data_o       (core_data),
        .deliver_o    (deliver),
        .parity_err_o (parity_err),
        .frame_err_o  (frame_err)
    );

    always_comb begin
        rd_mux = '0;
        case (addr_i)
            ADDR_DATA:      rd_mux = {24'd0, data_q};
            ADDR_VALID:     rd_mux = {31'd0, valid_q};
            ADDR_BUSY:      rd_mux = {31'd0, busy};
            ADDR_DIV:       rd_mux = {16'd0, div_q};
            ADDR_PARITY_EN: rd_mux = {31'd0, parity_en_q};
            ADDR_STOPBITS:  rd_mux = two_stop_q ? 32'd2 : 32'd1;
            ADDR_ERR:       rd_mux = {29'd0, err_q};
            default:        rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            read_data_o         <= '0;
            interrupt_request_o <= 1'b0;
            data_q              <= '0;
            valid_q             <= 1'b0;
            div_q               <= DEFAULT_DIV;
            parity_en_q         <= 1'b0;
            two_stop_q          <= 1'b0;
            err_q               <= '0;
        end else if (soft_rst) begin
            read_data_o         <= '0;
            interrupt_request_o <= 1'b0;
            data_q              <= '0;
            valid_q             <= 1'b0;
            div_q               <= DEFAULT_DIV;
            parity_en_q         <= 1'b0;
            two_stop_q          <= 1'b0;
            err_q               <= '0;
        end else begin
            if (rd) begin
                read_data_o <= rd_mux;
            end
            if (deliver) begin
                data_q <= core_data;
            end
            // Delivery outranks a same-cycle DATA read or interrupt return.
            valid_q             <= deliver | (valid_q & ~data_rd);
            interrupt_request_o <= deliver | (interrupt_request_o & ~data_rd & ~interrupt_return_i);
            err_q <= (err_wr ? 3'b000 : err_q)
                   | {deliver & valid_q & ~data_rd, frame_err, parity_err};
            if (wr && (addr_i == ADDR_DIV) && (write_data_i[15:0] >= 16'd4) && !busy) begin
                div_q <= write_data_i[15:0];
            end
            if (wr && (addr_i == ADDR_PARITY_EN)) begin
                parity_en_q <= write_data_i[0];
            end
            if (wr && (addr_i == ADDR_STOPBITS)) begin
                two_stop_q <= (write_data_i == 32'd2);
            end
        end
    end

endmodule
